// File: rtl/sysbus_pkg.sv
// rtl/sysbus_pkg.sv - Sysbus responder types, tag layout and line-index helper.
package sysbus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_WAIT,
    S_RESP,
    S_WDATA,
    S_WACK
  } resp_state_t;

  // Tag layout {dir, target, id} for the default 13-bit tag.
  localparam int TAG_ID_LSB     = 0;
  localparam int TAG_ID_W       = 8;
  localparam int TAG_TARGET_LSB = 8;
  localparam int TAG_TARGET_W   = 4;
  localparam int TAG_DIR_BIT    = 12;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic       SYSBUS_WRITE  = 1'b0;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

  function automatic logic [63:0] line_base(input logic [63:0] addr, input int beat_bits);
    logic [63:0] word;
    word = addr >> 3;
    return (word >> beat_bits) << beat_bits;
  endfunction

endpackage

// File: rtl/sysbus_mem_array.sv
// rtl/sysbus_mem_array.sv - DEPTH x DW word array, async read port, bus write muxed with backdoor preload.
module sysbus_mem_array #(
  parameter int DW    = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          init_we_i,
  input  logic [AW-1:0] init_addr_i,
  input  logic [DW-1:0] init_data_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  // Backdoor wins so a loader can always overwrite what the bus wrote.
  always_ff @(posedge clk_i) begin
    if (init_we_i) begin
      mem_q[init_addr_i] <= init_data_i;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sysbus_mem_responder.sv
// rtl/sysbus_mem_responder.sv - Memory-side Sysbus responder: line reads after fixed latency, line writes beat by beat.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int DEPTH          = 1024,
  parameter int BEATS          = 8,
  parameter int LATENCY        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0]  bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]   bus_reqtag,
  output logic                       bus_reqack,
  output logic                       bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]  bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]   bus_resptag,
  input  logic                       bus_respack,
  input  logic                       init_we,
  input  logic [$clog2(DEPTH)-1:0]   init_addr,
  input  logic [BUS_DATA_WIDTH-1:0]  init_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int BB = $clog2(BEATS);
  localparam int BW = BB + 1;
  localparam int LW = $clog2(LATENCY + 1);

  resp_state_t               state_q, state_d;
  logic [AW-1:0]             base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [BW-1:0]             beat_q, beat_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

  logic                      mem_we;
  logic [AW-1:0]             mem_waddr;
  logic [AW-1:0]             mem_raddr;
  logic [BUS_DATA_WIDTH-1:0] mem_rdata;
  logic [BW-1:0]             rd_beat;

  // Read port looks one beat ahead in RESP so an acked beat is replaced next cycle.
  assign rd_beat   = (state_q == S_RESP) ? beat_q + BW'(1) : beat_q;
  assign mem_raddr = base_q + AW'(rd_beat);
  assign mem_waddr = base_q + AW'(beat_q);

  sysbus_mem_array #(
    .DW    (BUS_DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i       (clk),
    .we_i        (mem_we),
    .waddr_i     (mem_waddr),
    .wdata_i     (bus_req),
    .init_we_i   (init_we),
    .init_addr_i (init_addr),
    .init_data_i (init_data),
    .raddr_i     (mem_raddr),
    .rdata_o     (mem_rdata)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    tag_d     = tag_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    reqack_d  = 1'b0;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;
    mem_we    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus_reqcyc) begin
          base_d   = AW'(line_base(64'(bus_req), BB));
          tag_d    = bus_reqtag;
          beat_d   = '0;
          lat_d    = '0;
          reqack_d = 1'b1;
          state_d  = S_ACK;
        end
      end
      S_ACK: begin
        state_d = (tag_q[BUS_TAG_WIDTH-1] == SYSBUS_READ) ? S_WAIT : S_WDATA;
      end
      S_WAIT: begin
        if (lat_q == LW'(LATENCY - 1)) begin
          lat_d     = '0;
          respcyc_d = 1'b1;
          resp_d    = mem_rdata;
          resptag_d = tag_q;
          state_d   = S_RESP;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      S_RESP: begin
        if (bus_respack) begin
          if (beat_q == BW'(BEATS - 1)) begin
            beat_d    = '0;
            respcyc_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
            resp_d = mem_rdata;
          end
        end
      end
      S_WDATA: begin
        if (bus_reqcyc) begin
          mem_we   = 1'b1;
          beat_d   = beat_q + BW'(1);
          reqack_d = 1'b1;
          state_d  = S_WACK;
        end
      end
      S_WACK: begin
        if (beat_q == BW'(BEATS)) begin
          beat_d  = '0;
          state_d = S_IDLE;
        end else begin
          state_d = S_WDATA;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      tag_q     <= tag_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;

  init_idle_a: assert property (@(posedge clk) disable iff (reset) init_we |-> state_q == S_IDLE);

endmodule
